sccb_target: RTL and testbench
==============================

SCCB_TARGET -- requirements
Module: sccb_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h21, 7-bit device address (write byte 8'h42, read byte 8'h43).
REQ-002 SHALL have parameter FILT_LEN, default 3, number of consecutive equal i_clk samples needed to accept an SCL/SDA level.
REQ-003 SHALL have port i_clk  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_scl  input  1  SCCB clock from the master, asynchronous.
REQ-006 SHALL have port i_sda  input  1  SCCB data line as sensed, asynchronous.
REQ-007 SHALL have port o_sda_oe  output  1  1 = pull SDA low, 0 = release SDA; the top level forms the open-drain pad.
REQ-008 SHALL have port o_wr_stb  output  1  one-cycle pulse per accepted write data byte.
REQ-009 SHALL have port o_wr_addr  output  8  register address of the current o_wr_stb.
REQ-010 SHALL have port o_wr_data  output  8  data byte of the current o_wr_stb.
REQ-011 SHALL have port o_busy  output  1  high from an address-matched START until the following STOP.

Function
REQ-012 SHALL pass i_scl and i_sda through a 2-FF synchroniser, then a FILT_LEN glitch filter; all decoding uses the filtered levels.
REQ-013 SHALL detect START as filtered SDA falling while SCL is high, and STOP as SDA rising while SCL is high. Both are valid in any state.
REQ-014 SHALL sample SDA on filtered SCL rising edges, MSB first, and change o_sda_oe only on filtered SCL falling edges.
REQ-015 SHALL implement the states IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and IGNORE.
REQ-016 IDLE -> DEV on START. A repeated START from any state -> DEV and keeps the sub-address pointer.
REQ-017 After 8 DEV bits: if bits[7:1] == DEV_ADDR, drive ACK (o_sda_oe=1) for the 9th SCL period. If the R/W bit is 0 -> SUB; if it is 1 -> RDATA. On mismatch -> IGNORE with SDA released.
REQ-018 After 8 SUB bits SHALL load the pointer, ACK, then go to WDATA.
REQ-019 After 8 WDATA bits SHALL write the register file at the pointer. In the same cycle it SHALL pulse o_wr_stb with o_wr_addr = pointer and o_wr_data = the byte, ACK, and stay in WDATA for further bytes.
REQ-020 In RDATA SHALL shift out reg[pointer] MSB first by driving o_sda_oe = ~bit, then release SDA during the master ACK bit.
REQ-021 In RDATA_ACK SHALL sample SDA at the 9th SCL rise. On 0 (master ACK) -> RDATA with the next byte. On 1 (NACK) -> IGNORE.
REQ-022 IGNORE SHALL keep SDA released and wait for START or STOP.
REQ-023 STOP SHALL return to IDLE in the cycle after detection, release SDA, deassert o_busy and keep the pointer.
REQ-024 The register file SHALL be 256 x 8, written only via SCCB, with power-on content 8'h00 and no reset.
REQ-025 The pointer SHALL wrap from 8'hFF to 8'h00.
REQ-026 A write and a read of the same address can never coincide in one cycle; read data is the byte latched at the first SCL falling edge of RDATA.

Reset
REQ-027 Asserting i_rst SHALL immediately release SDA and force o_sda_oe=0, o_wr_stb=0, o_wr_addr=0, o_wr_data=0, o_busy=0, state IDLE, pointer 8'h00, and all synchroniser/filter flops to 1 (bus idle).
REQ-028 Reset mid-transfer SHALL abandon the transfer. After release the block SHALL ignore bus activity until the next START.

Configuration
REQ-029 Macro SCCB_TARGET_AUTOINC_EN: when defined, the pointer SHALL increment after every written byte (REQ-019) and every transmitted read byte (REQ-020).
REQ-030 Without SCCB_TARGET_AUTOINC_EN the pointer SHALL hold, so successive bytes write or read the same register (OV7670 behaviour).

Structure
REQ-031 A shared package sccb_pkg SHALL hold the state enumeration, the constants SCCB_WR_ADDR=8'h42 and SCCB_RD_ADDR=8'h43, and the default FILT_LEN.
REQ-032 The synchroniser plus filter plus edge detect SHALL be one sub-module, sccb_line_filter, instantiated twice (SCL, SDA).

Verification
REQ-033 START, 42, 12, 80, STOP -> ACK on all three bytes; one o_wr_stb with addr 8'h12 and data 8'h80; reg[12]=80; o_busy low after STOP.
REQ-034 Write 8'h3A to 8'h40, then START, 42, 40, STOP, START, 43, read with master NACK -> SDA carries 8'h3A; SDA released after the NACK.
REQ-035 START, 44 (foreign address), 00 -> no ACK; o_sda_oe stays 0; no o_wr_stb; o_busy 0.
REQ-036 With AUTOINC_EN: START, 42, FF, 11, 22, STOP -> strobes (FF,11) and (00,22). Without it: strobes (FF,11) and (FF,22).
REQ-037 A 1-cycle SDA glitch while SCL is high -> no START or STOP detected, state unchanged.
REQ-038 Assert i_rst while driving the ACK of 42 -> o_sda_oe=0 within the same cycle; after release, a full write transaction succeeds.

Source files
------------

// File: rtl/sccb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sccb_pkg                                                     |
// | Description : Shared types and constants for the SCCB target: FSM state    |
// |               enumeration, bus address bytes and default filter length.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sccb_pkg;

    // Protocol states of the target FSM
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV       = 4'd1,
        ST_DEV_ACK   = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } sccb_state_e;

    // Device address byte with R/W = 0 (write) and R/W = 1 (read)
    localparam logic [7:0] SCCB_WR_ADDR = 8'h42;
    localparam logic [7:0] SCCB_RD_ADDR = 8'h43;

    // Default number of equal samples needed to accept a line level
    localparam int SCCB_FILT_LEN = 3;

    // True when the upper seven bits of an address byte select this device
    function automatic logic dev_match(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
        return addr_byte[7:1] == dev_addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sccb_line_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sccb_line_filter                                             |
// | Description : 2-FF synchroniser, FILT_LEN-sample glitch filter and edge    |
// |               detector for one SCCB line. Everything resets to the idle    |
// |               (high) level so no edge is reported out of reset.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sccb_line_filter
    import sccb_pkg::*;
#(
    parameter int FILT_LEN = SCCB_FILT_LEN
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int              CNT_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Accept a new level once FILT_LEN consecutive synchronised samples disagree with the current one
    always_comb begin
        sync1_d = i_line;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser, filter and edge-pulse registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/sccb_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sccb_target                                                  |
// | Description : SCCB (OV7670-style) target with a 256 x 8 register file.     |
// |               Writes: START, dev(W), sub-address, data... STOP.            |
// |               Reads : START, dev(R), data (master ACK/NACK)... STOP.       |
// |               Optional macro SCCB_TARGET_AUTOINC_EN makes the register     |
// |               pointer advance after every written or transmitted byte;     |
// |               without it the pointer holds.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = SCCB_WR_ADDR[7:1],
    parameter int         FILT_LEN = SCCB_FILT_LEN
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_stb,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_busy
);

`ifdef SCCB_TARGET_AUTOINC_EN
    localparam logic [7:0] PTR_STEP = 8'd1;
`else
    localparam logic [7:0] PTR_STEP = 8'd0;
`endif

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_line  (i_scl),
        .o_level (scl_lvl),
        .o_rise  (scl_rise),
        .o_fall  (scl_fall)
    );

    sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_line  (i_sda),
        .o_level (sda_lvl),
        .o_rise  (sda_rise),
        .o_fall  (sda_fall)
    );

    sccb_state_e state_q,   state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  sh_q,      sh_d;
    logic [7:0]  tx_q,      tx_d;
    logic [7:0]  ptr_q,     ptr_d;
    logic        rw_q,      rw_d;
    logic        phase_q,   phase_d;   // ACK states: ACK driven; RDATA_ACK: master acked
    logic        oe_q,      oe_d;
    logic        busy_q,    busy_d;
    logic        wr_stb_q,  wr_stb_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;

    logic [7:0]  mem_q [0:255];
    logic        mem_we;
    logic [7:0]  mem_rd;
    logic [7:0]  rx_byte;
    logic        bus_start;
    logic        bus_stop;

    assign bus_start = scl_lvl & sda_fall;
    assign bus_stop  = scl_lvl & sda_rise;
    assign rx_byte   = {sh_q, sda_lvl};
    assign mem_rd    = mem_q[ptr_q];

    // Next-state and datapath decode; START/STOP override every state
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        phase_d   = phase_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;

        if (bus_start) begin
            state_d   = ST_DEV;
            bit_cnt_d = 4'd0;
            phase_d   = 1'b0;
            oe_d      = 1'b0;
        end else if (bus_stop) begin
            state_d = ST_IDLE;
            phase_d = 1'b0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_DEV, ST_SUB, ST_WDATA: begin
                    if (scl_rise) begin
                        sh_d      = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            phase_d   = 1'b0;
                            case (state_q)
                                ST_DEV: begin
                                    if (dev_match(rx_byte, DEV_ADDR)) begin
                                        busy_d  = 1'b1;
                                        rw_d    = rx_byte[0];
                                        state_d = ST_DEV_ACK;
                                    end else begin
                                        busy_d  = 1'b0;
                                        state_d = ST_IGNORE;
                                    end
                                end
                                ST_SUB: begin
                                    ptr_d   = rx_byte;
                                    state_d = ST_SUB_ACK;
                                end
                                default: begin
                                    mem_we    = 1'b1;
                                    wr_stb_d  = 1'b1;
                                    wr_addr_d = ptr_q;
                                    wr_data_d = rx_byte;
                                    ptr_d     = ptr_q + PTR_STEP;
                                    state_d   = ST_WDATA_ACK;
                                end
                            endcase
                        end
                    end
                end

                // First SCL fall pulls SDA for the ACK bit, second fall releases it
                ST_DEV_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            oe_d    = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            oe_d      = 1'b0;
                            phase_d   = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (state_q == ST_DEV_ACK && rw_q) begin
                                state_d = ST_RDATA;
                                oe_d    = ~mem_rd[7];
                                tx_d    = {mem_rd[6:0], 1'b0};
                            end else if (state_q == ST_DEV_ACK) begin
                                state_d = ST_SUB;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end

                // Bit 7 is already on the line on entry; later bits follow each SCL fall
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            phase_d = 1'b0;
                            ptr_d   = ptr_q + PTR_STEP;
                            state_d = ST_RDATA_ACK;
                        end else begin
                            oe_d = ~tx_q[7];
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                    end
                end

                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_lvl) begin
                            phase_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d   = 1'b0;
                        bit_cnt_d = 4'd0;
                        oe_d      = ~mem_rd[7];
                        tx_d      = {mem_rd[6:0], 1'b0};
                        state_d   = ST_RDATA;
                    end
                end

                ST_IGNORE: begin
                    oe_d = 1'b0;
                end

                default: begin
                    oe_d = 1'b0;
                end
            endcase
        end
    end

    // FSM and registered outputs; reset clears SDA drive immediately
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            sh_q      <= 7'd0;
            tx_q      <= 8'd0;
            ptr_q     <= 8'h00;
            rw_q      <= 1'b0;
            phase_q   <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= 8'h00;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            phase_q   <= phase_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Register file: no reset, written only from the SCCB write path
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= rx_byte;
        end
    end

    assign o_sda_oe  = oe_q;
    assign o_wr_stb  = wr_stb_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sccb_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sccb_target                                               |
// | Description : Self-checking bench for sccb_target. A bit-banged SCCB       |
// |               master drives the bus; a byte-level model of the register    |
// |               file and pointer predicts write strobes and read data.       |
// |               Honours SCCB_TARGET_AUTOINC_EN like the design.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sccb_target;
    import sccb_pkg::*;

    localparam int H = 16;   // SCL high time in clk cycles
    localparam int Q = 8;    // SDA setup/hold around SCL edges
`ifdef SCCB_TARGET_AUTOINC_EN
    localparam logic [7:0] STEP = 8'd1;
`else
    localparam logic [7:0] STEP = 8'd0;
`endif

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic       wr_stb;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int         n_checks = 0;
    int         n_errors = 0;
    logic       oe_seen  = 1'b0;

    logic [7:0] ref_mem [256];
    logic [7:0] ref_ptr = 8'h00;
    wr_t        exp_wr [$];
    logic [7:0] payload [$];

    // Open-drain bus: line is low if either side pulls it
    assign sda_line = m_sda & ~sda_oe;

    sccb_target dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_scl     (m_scl),
        .i_sda     (sda_line),
        .o_sda_oe  (sda_oe),
        .o_wr_stb  (wr_stb),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write-strobe monitor: pops the next predicted write on every strobe
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (sda_oe) oe_seen = 1'b1;
            if (wr_stb) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected wr_stb: got addr 0x%0h data 0x%0h, expected no strobe", wr_addr, wr_data);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", {24'd0, wr_addr}, {24'd0, e.addr});
                    chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic b, input logic glitch);
        m_sda = b;
        clks(Q);
        m_scl = 1'b1;
        clks(H / 2);
        if (glitch) begin
            m_sda = ~b;
            clks(1);
            m_sda = b;
        end
        clks(H / 2);
        m_scl = 1'b0;
        clks(Q);
    endtask

    task automatic bit_in(output logic b);
        m_sda = 1'b1;
        clks(Q);
        m_scl = 1'b1;
        clks(H / 2);
        b = sda_line;
        clks(H / 2);
        m_scl = 1'b0;
        clks(Q);
    endtask

    task automatic bus_start();
        m_sda = 1'b1;
        clks(Q);
        m_scl = 1'b1;
        clks(H);
        m_sda = 1'b0;
        clks(H);
        m_scl = 1'b0;
        clks(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        clks(Q);
        m_scl = 1'b1;
        clks(H);
        m_sda = 1'b1;
        clks(H);
    endtask

    task automatic send_bits(input logic [7:0] v, input int glitch_pos);
        for (int i = 7; i >= 0; i--) bit_out(v[i], i == glitch_pos);
    endtask

    task automatic byte_out(input logic [7:0] v, input int glitch_pos, output logic ack);
        send_bits(v, glitch_pos);
        bit_in(ack);
    endtask

    task automatic byte_in(output logic [7:0] v, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            v[i] = b;
        end
        bit_out(nack, 1'b0);
    endtask

    // Write transaction of the bytes in payload starting at sub
    task automatic do_write(input logic [7:0] sub, input int glitch_pos);
        logic a;
        bus_start();
        byte_out(SCCB_WR_ADDR, -1, a);
        chk("dev ack", {31'd0, a}, 32'd0);
        chk("busy after dev ack", {31'd0, busy}, 32'd1);
        byte_out(sub, -1, a);
        chk("sub ack", {31'd0, a}, 32'd0);
        ref_ptr = sub;
        foreach (payload[k]) begin
            exp_wr.push_back({ref_ptr, payload[k]});
            ref_mem[ref_ptr] = payload[k];
            ref_ptr = ref_ptr + STEP;
            byte_out(payload[k], (k == 0) ? glitch_pos : -1, a);
            chk("data ack", {31'd0, a}, 32'd0);
        end
        bus_stop();
        clks(4);
        chk("busy after stop", {31'd0, busy}, 32'd0);
    endtask

    // Load the pointer; optionally leave the bus busy for a repeated START
    task automatic do_set_ptr(input logic [7:0] sub, input logic no_stop);
        logic a;
        bus_start();
        byte_out(SCCB_WR_ADDR, -1, a);
        chk("ptr dev ack", {31'd0, a}, 32'd0);
        byte_out(sub, -1, a);
        chk("ptr sub ack", {31'd0, a}, 32'd0);
        ref_ptr = sub;
        if (!no_stop) bus_stop();
    endtask

    // Read n bytes, ACK all but the last
    task automatic do_read(input int n);
        logic       a;
        logic [7:0] v;
        logic [7:0] e;
        bus_start();
        byte_out(SCCB_RD_ADDR, -1, a);
        chk("rd dev ack", {31'd0, a}, 32'd0);
        for (int i = 0; i < n; i++) begin
            e = ref_mem[ref_ptr];
            ref_ptr = ref_ptr + STEP;
            byte_in(v, i == n - 1);
            chk("read data", {24'd0, v}, {24'd0, e});
        end
        chk("sda released after nack", {31'd0, sda_oe}, 32'd0);
        bus_stop();
        clks(4);
        chk("busy after read stop", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic       a;
        int         w;
        int         n;
        logic [7:0] sub;
        logic [7:0] v;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        // Reset values
        clks(3);
        chk("reset oe", {31'd0, sda_oe}, 32'd0);
        chk("reset wr_stb", {31'd0, wr_stb}, 32'd0);
        chk("reset wr_addr", {24'd0, wr_addr}, 32'd0);
        chk("reset wr_data", {24'd0, wr_data}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        clks(5);

        // Basic write 42 12 80
        payload = '{8'h80};
        do_write(8'h12, -1);

        // Write 3A to 40, point at 40, read back with NACK; then reg 12
        payload = '{8'h3A};
        do_write(8'h40, -1);
        do_set_ptr(8'h40, 1'b0);
        do_read(1);
        do_set_ptr(8'h12, 1'b0);
        do_read(1);

        // Foreign device address: never acked, never driven
        oe_seen = 1'b0;
        bus_start();
        byte_out(8'h44, -1, a);
        chk("foreign addr nack", {31'd0, a}, 32'd1);
        byte_out(8'h00, -1, a);
        chk("foreign data nack", {31'd0, a}, 32'd1);
        chk("foreign oe never set", {31'd0, oe_seen}, 32'd0);
        chk("foreign busy", {31'd0, busy}, 32'd0);
        bus_stop();

        // Pointer wrap / hold across two data bytes
        payload = '{8'h11, 8'h22};
        do_write(8'hFF, -1);

        // One-cycle SDA glitch while SCL high: on a 1 bit (false START) and a 0 bit (false STOP)
        payload = '{8'hA5};
        do_write(8'h30, 7);
        payload = '{8'hA5};
        do_write(8'h31, 6);

        // Reset while the target drives the ACK of the address byte
        bus_start();
        v = SCCB_WR_ADDR;
        send_bits(v, -1);
        m_sda = 1'b1;
        w = 0;
        while (!sda_oe && w < 40) begin
            clks(1);
            w++;
        end
        chk("ack driven before reset", {31'd0, sda_oe}, 32'd1);
        rst = 1'b1;
        #1;
        chk("oe cleared by reset", {31'd0, sda_oe}, 32'd0);
        clks(2);
        chk("wr_addr cleared by reset", {24'd0, wr_addr}, 32'd0);
        chk("busy cleared by reset", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        ref_ptr = 8'h00;
        clks(5);
        m_scl = 1'b1;
        clks(H);
        m_scl = 1'b0;
        clks(Q);
        chk("oe idle after reset", {31'd0, sda_oe}, 32'd0);
        bus_stop();
        payload = '{8'h5C};
        do_write(8'h77, -1);
        do_set_ptr(8'h77, 1'b1);
        do_read(1);

        // Randomised write / read-back transactions
        for (int t = 0; t < 10; t++) begin
            sub = 8'($urandom);
            n = $urandom_range(1, 3);
            payload = {};
            for (int k = 0; k < n; k++) payload.push_back(8'($urandom));
            do_write(sub, -1);
            do_set_ptr(sub, 1'($urandom_range(0, 1)));
            do_read($urandom_range(1, n));
        end

        clks(10);
        chk("all predicted strobes seen", exp_wr.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
